// File: rtl/sr_stack_ctrl_pkg.sv
// Shared encodings for the hardware stack controller: FSM states, error causes
// and the custom RISC-V opcodes that drive push/pop.
package sr_stack_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2,
    ST_ERROR   = 2'd3
  } stackState_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_OVERFLOW  = 2'b01,
    ERR_UNDERFLOW = 2'b10
  } errCause_e;

  localparam logic [6:0] RVOP_PUSH = 7'b0001011;
  localparam logic [6:0] RVOP_POP  = 7'b0101011;

endpackage

// File: rtl/sr_stack_mem.sv
// Stack storage: DEPTH x WIDTH registers, one synchronous write port and two
// asynchronous read ports (top of stack and debug peek). Contents are never reset.
module sr_stack_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wrIdx,
  input  logic [WIDTH-1:0] wrData,
  input  logic [AW-1:0]    topIdx,
  output logic [WIDTH-1:0] topData,
  input  logic [AW-1:0]    peekIdx,
  output logic [WIDTH-1:0] peekData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wrIdx] <= wrData;
  end

  assign topData  = mem[topIdx];
  assign peekData = mem[peekIdx];

endmodule

// File: rtl/sr_stack_ctrl.sv
// Hardware stack controller for the CPU PUSH/POP instructions: FSM, entry count,
// index generation and status flags around an sr_stack_mem storage array.
module sr_stack_ctrl
  import sr_stack_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             error,
  output logic [1:0]       errCause,
  input  logic [AW-1:0]    dbgIdx,
  output logic [WIDTH-1:0] dbgData
);

  stackState_e stateQ, stateD;
  errCause_e   causeQ, causeD;
  logic [CW-1:0] countQ, countD;
  logic          memWe;
  logic [AW-1:0] memWrIdx;
  logic [AW-1:0] topIdx, peekIdx;
  logic [WIDTH-1:0] topData, peekData;

  // Entries live at 0..count-1 with the top at count-1; at count==DEPTH the low bits wrap to 0.
  assign topIdx  = countQ[AW-1:0] - AW'(1);
  assign peekIdx = topIdx - dbgIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= ST_EMPTY;
      countQ <= '0;
      causeQ <= ERR_NONE;
    end else begin
      stateQ <= stateD;
      countQ <= countD;
      causeQ <= causeD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    countD   = countQ;
    causeD   = causeQ;
    memWe    = 1'b0;
    memWrIdx = countQ[AW-1:0];
    if (clear) begin
      stateD = ST_EMPTY;
      countD = '0;
      causeD = ERR_NONE;
    end else begin
      unique case (stateQ)
        ST_EMPTY: begin
          if (push) begin
            memWe    = 1'b1;
            memWrIdx = '0;
            countD   = CW'(1);
            stateD   = ST_PARTIAL;
          end else if (pop) begin
            stateD = ST_ERROR;
            causeD = ERR_UNDERFLOW;
          end
        end
        ST_PARTIAL, ST_FULL: begin
          if (push && pop) begin
            memWe    = 1'b1;
            memWrIdx = topIdx;
          end else if (push) begin
            if (stateQ == ST_FULL) begin
              stateD = ST_ERROR;
              causeD = ERR_OVERFLOW;
            end else begin
              memWe  = 1'b1;
              countD = countQ + CW'(1);
              stateD = (countQ == CW'(DEPTH - 1)) ? ST_FULL : ST_PARTIAL;
            end
          end else if (pop) begin
            countD = countQ - CW'(1);
            stateD = (countQ == CW'(1)) ? ST_EMPTY : ST_PARTIAL;
          end
        end
        ST_ERROR: ;
        default: ;
      endcase
    end
  end

  always_comb begin
    count    = countQ;
    empty    = (countQ == '0);
    full     = (countQ == CW'(DEPTH));
    error    = (stateQ == ST_ERROR);
    errCause = causeQ;
    popData  = empty ? '0 : topData;
    dbgData  = ({1'b0, dbgIdx} < countQ) ? peekData : '0;
  end

  sr_stack_mem #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) u_mem (
    .clk     (clk),
    .we      (memWe),
    .wrIdx   (memWrIdx),
    .wrData  (pushData),
    .topIdx  (topIdx),
    .topData (topData),
    .peekIdx (peekIdx),
    .peekData(peekData)
  );

endmodule
